mandel_sched: RTL and testbench

Frame-level scheduler for the fixed-point Mandelbrot engines. Walks an H_RES×V_RES grid of complex coordinates, dispatches each pixel to the lowest-index free engine out of NUM_ENG engines, and collects the iteration counts. It writes each result, with its linear pixel address, to the framebuffer write port at most one per cycle. It sits between the render-control logic (start/params) and the engine array plus framebuffer.

---
 rtl/mandel_sched.sv | 191 +++++++++++++++++++
 tb/tb_mandel_sched.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mandel_sched.sv
// mandel_sched: walks an H_RES x V_RES coordinate grid, hands each pixel to the
// lowest-index free Mandelbrot engine and writes the returned iteration counts
// to the framebuffer together with the pixel's linear address.
module mandel_sched #(
    parameter int unsigned FP_WIDTH = 25,
    parameter int unsigned ITERW    = 8,
    parameter int unsigned NUM_ENG  = 4,
    parameter int unsigned H_RES    = 320,
    parameter int unsigned V_RES    = 180,
    parameter int unsigned ADDRW    = $clog2(H_RES * V_RES)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [FP_WIDTH-1:0]      re_start,
    input  logic [FP_WIDTH-1:0]      im_start,
    input  logic [FP_WIDTH-1:0]      step,
    output logic                     busy,
    output logic                     done,
    output logic [NUM_ENG-1:0]       eng_start,
    output logic [FP_WIDTH-1:0]      eng_re,
    output logic [FP_WIDTH-1:0]      eng_im,
    input  logic [NUM_ENG-1:0]       eng_done,
    input  logic [NUM_ENG*ITERW-1:0] eng_iter,
    output logic                     pix_we,
    output logic [ADDRW-1:0]         pix_addr,
    output logic [ITERW-1:0]         pix_iter
);

    localparam int unsigned        COLW      = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam logic [ADDRW-1:0]   LAST_ADDR = ADDRW'(H_RES * V_RES - 1);
    localparam logic [COLW-1:0]    LAST_COL  = COLW'(H_RES - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StFin} state_e;

    state_e               state_q, state_d;
    logic [FP_WIDTH-1:0]  re0_q, step_q;
    logic [FP_WIDTH-1:0]  cur_re_q, cur_re_d, cur_im_q, cur_im_d;
    logic [COLW-1:0]      col_q, col_d;
    logic [ADDRW-1:0]     addr_q, addr_d;
    logic [NUM_ENG-1:0]   run_q, run_d, pend_q, pend_d;
    logic [ADDRW-1:0]     tag_q [NUM_ENG];

    logic                 in_idle, disp_go, wb_go, last_disp;
    logic [NUM_ENG-1:0]   free, disp_oh, wb_oh;
    logic [FP_WIDTH-1:0]  src_re, src_im, src_base, src_step;
    logic [COLW-1:0]      src_col;
    logic [ADDRW-1:0]     src_addr;

    logic                 busy_d, done_d, pix_we_d;
    logic [NUM_ENG-1:0]   eng_start_d;
    logic [FP_WIDTH-1:0]  eng_re_d, eng_im_d;
    logic [ADDRW-1:0]     pix_addr_d;
    logic [ITERW-1:0]     pix_iter_d;

    // Dispatch / write-back arbitration. The first pixel is dispatched in the IDLE
    // cycle straight from the start inputs so that eng_start follows start by one cycle.
    always_comb begin
        in_idle = (state_q == StIdle);
        free    = ~run_q & ~pend_q;
        disp_oh = '0;
        wb_oh   = '0;
        for (int k = NUM_ENG - 1; k >= 0; k--) begin
            if (free[k]) begin
                disp_oh    = '0;
                disp_oh[k] = 1'b1;
            end
            if (pend_q[k]) begin
                wb_oh    = '0;
                wb_oh[k] = 1'b1;
            end
        end
        disp_go   = ((in_idle && start) || (state_q == StRun)) && (free != '0);
        wb_go     = ((state_q == StRun) || (state_q == StDrain)) && (pend_q != '0);
        src_re    = in_idle ? re_start : cur_re_q;
        src_im    = in_idle ? im_start : cur_im_q;
        src_base  = in_idle ? re_start : re0_q;
        src_step  = in_idle ? step : step_q;
        src_col   = in_idle ? '0 : col_q;
        src_addr  = in_idle ? '0 : addr_q;
        last_disp = disp_go && (src_addr == LAST_ADDR);
    end

    // Coordinate walk and per-engine run/pend flags.
    always_comb begin
        cur_re_d = cur_re_q;
        cur_im_d = cur_im_q;
        col_d    = col_q;
        addr_d   = addr_q;
        if (disp_go) begin
            addr_d = src_addr + ADDRW'(1);
            if (src_col == LAST_COL) begin
                col_d    = '0;
                cur_re_d = src_base;
                cur_im_d = src_im - src_step;
            end else begin
                col_d    = src_col + COLW'(1);
                cur_re_d = src_re + src_step;
                cur_im_d = src_im;
            end
        end
        // eng_done only counts for a running engine; run is never set while idle.
        run_d  = (run_q & ~eng_done) | (disp_go ? disp_oh : '0);
        pend_d = (pend_q & ~(wb_go ? wb_oh : '0)) | (run_q & eng_done);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = last_disp ? StDrain : StRun;
            StRun:   if (last_disp) state_d = StDrain;
            StDrain: if ((run_q == '0) && (pend_q == '0)) state_d = StFin;
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        busy_d      = (state_d != StIdle);
        done_d      = (state_d == StFin);
        eng_start_d = disp_go ? disp_oh : '0;
        eng_re_d    = disp_go ? src_re : eng_re;
        eng_im_d    = disp_go ? src_im : eng_im;
        pix_we_d    = wb_go;
        pix_addr_d  = pix_addr;
        pix_iter_d  = pix_iter;
        for (int k = 0; k < NUM_ENG; k++) begin
            if (wb_go && wb_oh[k]) begin
                pix_addr_d = tag_q[k];
                pix_iter_d = eng_iter[k*ITERW +: ITERW];
            end
        end
    end

    // Datapath, flags and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            re0_q     <= '0;
            step_q    <= '0;
            cur_re_q  <= '0;
            cur_im_q  <= '0;
            col_q     <= '0;
            addr_q    <= '0;
            run_q     <= '0;
            pend_q    <= '0;
            for (int k = 0; k < NUM_ENG; k++) tag_q[k] <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            eng_start <= '0;
            eng_re    <= '0;
            eng_im    <= '0;
            pix_we    <= 1'b0;
            pix_addr  <= '0;
            pix_iter  <= '0;
        end else begin
            if (in_idle && start) begin
                re0_q  <= re_start;
                step_q <= step;
            end
            cur_re_q  <= cur_re_d;
            cur_im_q  <= cur_im_d;
            col_q     <= col_d;
            addr_q    <= addr_d;
            run_q     <= run_d;
            pend_q    <= pend_d;
            for (int k = 0; k < NUM_ENG; k++) begin
                if (disp_go && disp_oh[k]) tag_q[k] <= src_addr;
            end
            busy      <= busy_d;
            done      <= done_d;
            eng_start <= eng_start_d;
            eng_re    <= eng_re_d;
            eng_im    <= eng_im_d;
            pix_we    <= pix_we_d;
            pix_addr  <= pix_addr_d;
            pix_iter  <= pix_iter_d;
        end
    end

endmodule

// File: tb/tb_mandel_sched.sv
// Directed bench for mandel_sched: three instances (1 engine 2x2, 4 engines 8x4,
// 4 engines 1x2) each driven by a behavioural engine model.
module tb_mandel_sched;

    localparam int FPW  = 25;
    localparam int ONE  = 1 << 21;
    localparam int RE_B = -5242880;  // -2.5
    localparam int IM_B = 2359296;   // 1.125
    localparam int ST_B = 196608;    // 0.09375

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic [FPW-1:0] re_start, im_start, step;
    logic           start_a, start_b, start_c;
    int             cyc = 0;
    int             vectors = 0;
    int             miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- instance A: 1 engine, 2x2 ----------------
    logic           busy_a, done_a, pix_we_a;
    logic [0:0]     eng_start_a, eng_done_a;
    logic [FPW-1:0] eng_re_a, eng_im_a;
    logic [7:0]     eng_iter_a, pix_iter_a;
    logic [1:0]     pix_addr_a;
    logic           done_r_a, force_a;
    int             cnt_a;

    mandel_sched #(.FP_WIDTH(FPW), .ITERW(8), .NUM_ENG(1), .H_RES(2), .V_RES(2)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .re_start(re_start), .im_start(im_start),
        .step(step), .busy(busy_a), .done(done_a), .eng_start(eng_start_a), .eng_re(eng_re_a),
        .eng_im(eng_im_a), .eng_done(eng_done_a), .eng_iter(eng_iter_a), .pix_we(pix_we_a),
        .pix_addr(pix_addr_a), .pix_iter(pix_iter_a)
    );

    // ---------------- instance B: 4 engines, 8x4 ----------------
    logic           busy_b, done_b, pix_we_b;
    logic [3:0]     eng_start_b, eng_done_b, done_r_b;
    logic [FPW-1:0] eng_re_b, eng_im_b;
    logic [31:0]    eng_iter_b;
    logic [7:0]     pix_iter_b, iter_r_b [4];
    logic [4:0]     pix_addr_b;
    int             cnt_b [4];
    int             lat_b [4];
    bit             rand_b, mode_b;

    mandel_sched #(.FP_WIDTH(FPW), .ITERW(8), .NUM_ENG(4), .H_RES(8), .V_RES(4)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .re_start(re_start), .im_start(im_start),
        .step(step), .busy(busy_b), .done(done_b), .eng_start(eng_start_b), .eng_re(eng_re_b),
        .eng_im(eng_im_b), .eng_done(eng_done_b), .eng_iter(eng_iter_b), .pix_we(pix_we_b),
        .pix_addr(pix_addr_b), .pix_iter(pix_iter_b)
    );

    // ---------------- instance C: 4 engines, 1x2 ----------------
    logic           busy_c, done_c, pix_we_c;
    logic [3:0]     eng_start_c, eng_done_c, done_r_c;
    logic [FPW-1:0] eng_re_c, eng_im_c;
    logic [31:0]    eng_iter_c;
    logic [7:0]     pix_iter_c, iter_r_c [4];
    logic [0:0]     pix_addr_c;
    int             cnt_c [4];

    mandel_sched #(.FP_WIDTH(FPW), .ITERW(8), .NUM_ENG(4), .H_RES(1), .V_RES(2)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .re_start(re_start), .im_start(im_start),
        .step(step), .busy(busy_c), .done(done_c), .eng_start(eng_start_c), .eng_re(eng_re_c),
        .eng_im(eng_im_c), .eng_done(eng_done_c), .eng_iter(eng_iter_c), .pix_we(pix_we_c),
        .pix_addr(pix_addr_c), .pix_iter(pix_iter_c)
    );

    // Golden iteration function shared by the engine models and the expectations.
    function automatic logic [7:0] iter_fn(input logic [FPW-1:0] re, input logic [FPW-1:0] im);
        return re[24:17] ^ im[22:15] ^ 8'h5A;
    endfunction

    // Engine models: result captured at start, eng_done pulses cnt+1 cycles later.
    assign eng_done_a = done_r_a | force_a;
    assign eng_done_b = done_r_b;
    assign eng_done_c = done_r_c;
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            eng_iter_b[k*8 +: 8] = iter_r_b[k];
            eng_iter_c[k*8 +: 8] = iter_r_c[k];
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a <= 0; done_r_a <= 1'b0; eng_iter_a <= '0;
        end else begin
            done_r_a <= 1'b0;
            if (eng_start_a[0]) begin
                cnt_a <= 5;
                eng_iter_a <= iter_fn(eng_re_a, eng_im_a);
            end else if (cnt_a == 1) begin
                cnt_a <= 0; done_r_a <= 1'b1;
            end else if (cnt_a > 1) begin
                cnt_a <= cnt_a - 1;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_r_b <= '0;
            for (int k = 0; k < 4; k++) begin cnt_b[k] <= 0; iter_r_b[k] <= '0; end
        end else begin
            for (int k = 0; k < 4; k++) begin
                done_r_b[k] <= 1'b0;
                if (eng_start_b[k]) begin
                    cnt_b[k] <= rand_b ? int'($urandom_range(300, 1)) : lat_b[k];
                    iter_r_b[k] <= mode_b ? 8'(10 + k) : iter_fn(eng_re_b, eng_im_b);
                end else if (cnt_b[k] == 1) begin
                    cnt_b[k] <= 0; done_r_b[k] <= 1'b1;
                end else if (cnt_b[k] > 1) begin
                    cnt_b[k] <= cnt_b[k] - 1;
                end
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_r_c <= '0;
            for (int k = 0; k < 4; k++) begin cnt_c[k] <= 0; iter_r_c[k] <= '0; end
        end else begin
            for (int k = 0; k < 4; k++) begin
                done_r_c[k] <= 1'b0;
                if (eng_start_c[k]) begin
                    cnt_c[k] <= 3;
                    iter_r_c[k] <= iter_fn(eng_re_c, eng_im_c);
                end else if (cnt_c[k] == 1) begin
                    cnt_c[k] <= 0; done_r_c[k] <= 1'b1;
                end else if (cnt_c[k] > 1) begin
                    cnt_c[k] <= cnt_c[k] - 1;
                end
            end
        end
    end

    // Monitors, sampled mid-cycle.
    int             w_addr_a[$], w_iter_a[$], w_cyc_a[$], s_cyc_a[$], ed_cyc_a[$];
    logic [FPW-1:0] s_re_a[$], s_im_a[$];
    int             w_addr_b[$], w_iter_b[$], w_cyc_b[$];
    int             w_addr_c[$], w_iter_c[$];
    logic [3:0]     started_c;
    int             done_cnt_a, done_cyc_a, done_cnt_b, done_cyc_b, done_cnt_c;

    always @(negedge clk) begin
        if (pix_we_a) begin
            w_addr_a.push_back(int'(pix_addr_a)); w_iter_a.push_back(int'(pix_iter_a));
            w_cyc_a.push_back(cyc);
        end
        if (eng_start_a != '0) begin
            s_re_a.push_back(eng_re_a); s_im_a.push_back(eng_im_a); s_cyc_a.push_back(cyc);
        end
        if (eng_done_a[0]) ed_cyc_a.push_back(cyc);
        if (done_a) begin done_cnt_a++; done_cyc_a = cyc; end
        if (pix_we_b) begin
            w_addr_b.push_back(int'(pix_addr_b)); w_iter_b.push_back(int'(pix_iter_b));
            w_cyc_b.push_back(cyc);
        end
        if (done_b) begin done_cnt_b++; done_cyc_b = cyc; end
        if (pix_we_c) begin
            w_addr_c.push_back(int'(pix_addr_c)); w_iter_c.push_back(int'(pix_iter_c));
        end
        started_c = started_c | eng_start_c;
        if (done_c) done_cnt_c++;
    end

    task automatic clear_mon();
        w_addr_a.delete(); w_iter_a.delete(); w_cyc_a.delete(); s_cyc_a.delete();
        ed_cyc_a.delete(); s_re_a.delete(); s_im_a.delete();
        w_addr_b.delete(); w_iter_b.delete(); w_cyc_b.delete();
        w_addr_c.delete(); w_iter_c.delete();
        started_c = '0;
        done_cnt_a = 0; done_cnt_b = 0; done_cnt_c = 0; done_cyc_a = 0; done_cyc_b = 0;
    endtask

    // Pulse start for one cycle; returns at mid-cycle t+1.
    task automatic start_frame(input int which, input int re, input int im, input int st);
        @(negedge clk);
        re_start = FPW'(re); im_start = FPW'(im); step = FPW'(st);
        if (which == 0) start_a = 1'b1;
        else if (which == 1) start_b = 1'b1;
        else start_c = 1'b1;
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        #1;
    endtask

    // Returns just after mid-cycle of the done cycle, or flags a timeout.
    task automatic wait_done(input int which, input int budget, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = (which == 0) ? done_a : (which == 1) ? done_b : done_c;
        end
        #1;
        if (!seen) begin
            vectors++; miscompares++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
        end
    endtask

    int exp_re[4] = '{-4194304, -3145728, -4194304, -3145728};
    int exp_im[4] = '{2097152, 2097152, 1048576, 1048576};

    task automatic test_reset();
        @(negedge clk); #1;
        vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy_a); end
        vectors++; if (done_a !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b want 0", done_a); end
        vectors++; if (eng_start_a !== 1'b0) begin miscompares++; $display("FAIL rst_eng_start: got %b want 0", eng_start_a); end
        vectors++; if (eng_re_a !== '0) begin miscompares++; $display("FAIL rst_eng_re: got %h want 0", eng_re_a); end
        vectors++; if (eng_im_a !== '0) begin miscompares++; $display("FAIL rst_eng_im: got %h want 0", eng_im_a); end
        vectors++; if (pix_we_a !== 1'b0) begin miscompares++; $display("FAIL rst_pix_we: got %b want 0", pix_we_a); end
        vectors++; if (pix_addr_a !== '0) begin miscompares++; $display("FAIL rst_pix_addr: got %h want 0", pix_addr_a); end
        vectors++; if (pix_iter_a !== '0) begin miscompares++; $display("FAIL rst_pix_iter: got %h want 0", pix_iter_a); end
        vectors++; if ({busy_b, eng_start_b, busy_c, eng_start_c} !== '0) begin
            miscompares++; $display("FAIL rst_bc: got %b want 0", {busy_b, eng_start_b, busy_c, eng_start_c});
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // 2x2 frame, one engine, latency 5: coordinate walk, order, latencies, done timing.
    task automatic test_basic();
        int n;
        clear_mon();
        start_frame(0, -2 * ONE, ONE, ONE / 2);
        vectors++; if (busy_a !== 1'b1) begin miscompares++; $display("FAIL basic_busy_t1: got %b want 1", busy_a); end
        vectors++; if (eng_start_a !== 1'b1) begin miscompares++; $display("FAIL basic_start_t1: got %b want 1", eng_start_a); end
        wait_done(0, 300, "basic");
        vectors++; if (s_re_a.size() != 4) begin miscompares++; $display("FAIL basic_dispatches: got %0d want 4", s_re_a.size()); end
        n = (s_re_a.size() < 4) ? s_re_a.size() : 4;
        for (int i = 0; i < n; i++) begin
            vectors++; if (s_re_a[i] !== FPW'(exp_re[i])) begin miscompares++; $display("FAIL basic_re%0d: got %h want %h", i, s_re_a[i], FPW'(exp_re[i])); end
            vectors++; if (s_im_a[i] !== FPW'(exp_im[i])) begin miscompares++; $display("FAIL basic_im%0d: got %h want %h", i, s_im_a[i], FPW'(exp_im[i])); end
        end
        vectors++; if (w_addr_a.size() != 4 || ed_cyc_a.size() != 4) begin
            miscompares++; $display("FAIL basic_writes: got %0d writes %0d eng_done want 4", w_addr_a.size(), ed_cyc_a.size());
        end
        n = (w_addr_a.size() < 4) ? w_addr_a.size() : 4;
        n = (ed_cyc_a.size() < n) ? ed_cyc_a.size() : n;
        for (int i = 0; i < n; i++) begin
            vectors++; if (w_addr_a[i] != i) begin miscompares++; $display("FAIL basic_addr%0d: got %0d want %0d", i, w_addr_a[i], i); end
            vectors++; if (w_iter_a[i] != int'(iter_fn(FPW'(exp_re[i]), FPW'(exp_im[i])))) begin
                miscompares++; $display("FAIL basic_iter%0d: got %0d want %0d", i, w_iter_a[i], iter_fn(FPW'(exp_re[i]), FPW'(exp_im[i])));
            end
            vectors++; if (w_cyc_a[i] != ed_cyc_a[i] + 2) begin
                miscompares++; $display("FAIL basic_wb_lat%0d: got %0d want 2", i, w_cyc_a[i] - ed_cyc_a[i]);
            end
            if (i < 3 && s_cyc_a.size() > i + 1) begin
                vectors++; if (s_cyc_a[i+1] != w_cyc_a[i] + 1) begin
                    miscompares++; $display("FAIL basic_redispatch%0d: got %0d want 1", i, s_cyc_a[i+1] - w_cyc_a[i]);
                end
            end
        end
        vectors++; if (done_cnt_a != 1) begin miscompares++; $display("FAIL basic_done_cnt: got %0d want 1", done_cnt_a); end
        if (w_cyc_a.size() > 0) begin
            vectors++; if (done_cyc_a <= w_cyc_a[$]) begin miscompares++; $display("FAIL basic_done_after_write: done %0d last write %0d", done_cyc_a, w_cyc_a[$]); end
        end
        vectors++; if (busy_a !== 1'b1) begin miscompares++; $display("FAIL basic_busy_done_cycle: got %b want 1", busy_a); end
        @(negedge clk); #1;
        vectors++; if ({busy_a, done_a} !== 2'b00) begin miscompares++; $display("FAIL basic_after_done: got busy,done=%b want 00", {busy_a, done_a}); end
    endtask

    // All four engines finish together: four back-to-back writes in engine order.
    task automatic test_same_cycle();
        int seen[32];
        lat_b = '{8, 7, 6, 5}; rand_b = 1'b0; mode_b = 1'b1;
        clear_mon();
        start_frame(1, RE_B, IM_B, ST_B);
        wait_done(1, 2000, "same_cycle");
        vectors++; if (w_addr_b.size() != 32) begin miscompares++; $display("FAIL same_writes: got %0d want 32", w_addr_b.size()); end
        if (w_addr_b.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                vectors++; if (w_addr_b[i] != i || w_iter_b[i] != 10 + i || w_cyc_b[i] != w_cyc_b[0] + i) begin
                    miscompares++; $display("FAIL same_wr%0d: got addr %0d iter %0d dcyc %0d want %0d %0d %0d",
                                            i, w_addr_b[i], w_iter_b[i], w_cyc_b[i] - w_cyc_b[0], i, 10 + i, i);
                end
            end
        end
        foreach (seen[a]) seen[a] = 0;
        foreach (w_addr_b[j]) if (w_addr_b[j] < 32) seen[w_addr_b[j]]++;
        for (int a = 0; a < 32; a += 5) begin
            vectors++; if (seen[a] != 1) begin miscompares++; $display("FAIL same_once%0d: got %0d want 1", a, seen[a]); end
        end
        vectors++; if (done_cnt_b != 1) begin miscompares++; $display("FAIL same_done_cnt: got %0d want 1", done_cnt_b); end
        repeat (2) @(negedge clk);
    endtask

    // Random latencies: every address once with the golden iteration value.
    task automatic test_random();
        int seen[32];
        int a, re, im;
        rand_b = 1'b1; mode_b = 1'b0;
        clear_mon();
        start_frame(1, RE_B, IM_B, ST_B);
        wait_done(1, 20000, "random");
        vectors++; if (w_addr_b.size() != 32) begin miscompares++; $display("FAIL rand_writes: got %0d want 32", w_addr_b.size()); end
        foreach (seen[i]) seen[i] = 0;
        foreach (w_addr_b[j]) begin
            a  = w_addr_b[j];
            if (a < 32) seen[a]++;
            re = RE_B + (a % 8) * ST_B;
            im = IM_B - (a / 8) * ST_B;
            vectors++; if (w_iter_b[j] != int'(iter_fn(FPW'(re), FPW'(im)))) begin
                miscompares++; $display("FAIL rand_iter_a%0d: got %0d want %0d", a, w_iter_b[j], iter_fn(FPW'(re), FPW'(im)));
            end
        end
        for (int i = 0; i < 32; i++) begin
            vectors++; if (seen[i] != 1) begin miscompares++; $display("FAIL rand_once%0d: got %0d want 1", i, seen[i]); end
        end
        vectors++; if (done_cnt_b != 1) begin miscompares++; $display("FAIL rand_done_cnt: got %0d want 1", done_cnt_b); end
        if (w_cyc_b.size() > 0) begin
            vectors++; if (done_cyc_b <= w_cyc_b[$]) begin miscompares++; $display("FAIL rand_done_after_write: done %0d last write %0d", done_cyc_b, w_cyc_b[$]); end
        end
        repeat (2) @(negedge clk);
    endtask

    // start mid-frame and in the done cycle, with other coordinates, is ignored.
    task automatic test_restart_ignored();
        int n;
        clear_mon();
        start_frame(0, -2 * ONE, ONE, ONE / 2);
        repeat (3) @(negedge clk);
        re_start = FPW'(ONE); im_start = FPW'(-ONE); step = FPW'(ONE / 4); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        wait_done(0, 300, "restart");
        start_a = 1'b1;
        @(negedge clk); start_a = 1'b0; #1;
        vectors++; if ({busy_a, eng_start_a} !== 2'b00) begin miscompares++; $display("FAIL restart_done_cycle: got busy,start=%b want 00", {busy_a, eng_start_a}); end
        repeat (3) @(negedge clk); #1;
        vectors++; if (s_re_a.size() != 4 || w_addr_a.size() != 4) begin
            miscompares++; $display("FAIL restart_counts: got %0d dispatches %0d writes want 4 4", s_re_a.size(), w_addr_a.size());
        end
        n = (s_re_a.size() < 4) ? s_re_a.size() : 4;
        for (int i = 0; i < n; i++) begin
            vectors++; if (s_re_a[i] !== FPW'(exp_re[i]) || s_im_a[i] !== FPW'(exp_im[i])) begin
                miscompares++; $display("FAIL restart_coord%0d: got %h,%h want %h,%h", i, s_re_a[i], s_im_a[i], FPW'(exp_re[i]), FPW'(exp_im[i]));
            end
        end
        vectors++; if (done_cnt_a != 1) begin miscompares++; $display("FAIL restart_done_cnt: got %0d want 1", done_cnt_a); end
    endtask

    // Asynchronous reset mid-frame, spurious eng_done afterwards, then a full frame.
    task automatic test_reset_run();
        clear_mon();
        start_frame(0, -2 * ONE, ONE, ONE / 2);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++; if ({busy_a, done_a, eng_start_a, eng_re_a, eng_im_a, pix_we_a, pix_addr_a, pix_iter_a} !== '0) begin
            miscompares++; $display("FAIL rstrun_outputs: got %h want 0",
                {busy_a, done_a, eng_start_a, eng_re_a, eng_im_a, pix_we_a, pix_addr_a, pix_iter_a});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_mon();
        @(negedge clk); force_a = 1'b1;
        @(negedge clk); force_a = 1'b0;
        repeat (6) @(negedge clk); #1;
        vectors++; if (w_addr_a.size() != 0 || s_re_a.size() != 0) begin
            miscompares++; $display("FAIL rstrun_spurious: got %0d writes %0d starts want 0 0", w_addr_a.size(), s_re_a.size());
        end
        clear_mon();
        start_frame(0, -2 * ONE, ONE, ONE / 2);
        wait_done(0, 300, "rstrun");
        vectors++; if (w_addr_a.size() != 4) begin miscompares++; $display("FAIL rstrun_writes: got %0d want 4", w_addr_a.size()); end
        for (int i = 0; i < w_addr_a.size() && i < 4; i++) begin
            vectors++; if (w_addr_a[i] != i || w_iter_a[i] != int'(iter_fn(FPW'(exp_re[i]), FPW'(exp_im[i])))) begin
                miscompares++; $display("FAIL rstrun_wr%0d: got addr %0d iter %0d want %0d %0d", i, w_addr_a[i], w_iter_a[i],
                                        i, iter_fn(FPW'(exp_re[i]), FPW'(exp_im[i])));
            end
        end
        vectors++; if (done_cnt_a != 1) begin miscompares++; $display("FAIL rstrun_done_cnt: got %0d want 1", done_cnt_a); end
        repeat (2) @(negedge clk);
    endtask

    // 1x2 frame on four engines: only engines 0 and 1 used, row wrap on every pixel.
    task automatic test_small_frame();
        logic [7:0] e0, e1;
        e0 = iter_fn(FPW'(-2 * ONE), FPW'(ONE));
        e1 = iter_fn(FPW'(-2 * ONE), FPW'(ONE / 2));
        clear_mon();
        start_frame(2, -2 * ONE, ONE, ONE / 2);
        wait_done(2, 300, "small");
        vectors++; if (started_c !== 4'b0011) begin miscompares++; $display("FAIL small_engines: got %b want 0011", started_c); end
        vectors++; if (w_addr_c.size() != 2) begin miscompares++; $display("FAIL small_writes: got %0d want 2", w_addr_c.size()); end
        if (w_addr_c.size() == 2) begin
            vectors++; if (w_addr_c[0] != 0 || w_iter_c[0] != int'(e0)) begin
                miscompares++; $display("FAIL small_wr0: got addr %0d iter %0d want 0 %0d", w_addr_c[0], w_iter_c[0], e0);
            end
            vectors++; if (w_addr_c[1] != 1 || w_iter_c[1] != int'(e1)) begin
                miscompares++; $display("FAIL small_wr1: got addr %0d iter %0d want 1 %0d", w_addr_c[1], w_iter_c[1], e1);
            end
        end
        vectors++; if (done_cnt_c != 1) begin miscompares++; $display("FAIL small_done_cnt: got %0d want 1", done_cnt_c); end
    endtask

    initial begin
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; force_a = 1'b0;
        re_start = '0; im_start = '0; step = '0;
        rand_b = 1'b0; mode_b = 1'b0; lat_b = '{5, 5, 5, 5};
        clear_mon();
        test_reset();
        test_basic();
        test_same_cycle();
        test_random();
        test_restart_ignored();
        test_reset_run();
        test_small_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
